se_sram_srw_arbiter: RTL and testbench
======================================

// Module: se_sram_srw_arbiter
// PURPOSE
//  Round-robin arbiter sharing one single-port SRAM (se_sram_srw) between num_req requesters.
//  Per requester: req/ack handshake with one-cycle acceptance; ordered read-data return with a
//  one-hot valid. Sits directly in front of the SRAM; its sram_* outputs drive the SRAM ports.
//  Sustains one access per enabled cycle.
// PARAMETERS
//  address_width  16  SRAM address bits
//  data_width     8   SRAM data bits
//  num_req        4   requesters, 2..8
//  idx_width      2   clog2(num_req); set consistently by the instantiator
// PORTS
//  sram_clock           in   1                  clock; all state on posedge
//  sram_clock__enable   in   1                  clock enable; state advances only when high
//  sram_reset_n         in   1                  asynchronous reset, active low
//  req                  in   num_req            request, per requester; held until acked
//  req_read_not_write   in   num_req            1=read, 0=write
//  req_address          in   num_req*addr_w     requester i at [i*address_width +: address_width]
//  req_write_data       in   num_req*data_w     requester i at [i*data_width +: data_width]
//  ack                  out  num_req            one-hot, combinational; request accepted at this edge
//  rdata_valid          out  num_req            one-hot, registered; rdata belongs to this requester
//  rdata                out  data_width         = sram_data_in (pass-through)
//  sram_select          out  1                  registered, to SRAM select
//  sram_read_not_write  out  1                  registered, to SRAM read_not_write
//  sram_address         out  address_width      registered, to SRAM address
//  sram_write_data      out  data_width         registered, to SRAM write_data
//  sram_data_in         in   data_width         from SRAM data_out
// BEHAVIOUR
//  - Reset (async, sram_reset_n=0): sram_select=0, sram_read_not_write=0, sram_address=0,
//    sram_write_data=0, rdata_valid=0, rd_pend=0, last_grant=num_req-1 (requester 0 has first priority).
//    ack is 0 while reset is asserted.
//  - Arbitration: winner = first i with req[i]=1, searched from (last_grant+1) mod num_req upward,
//    with wrap-around. ack[winner]=1 only if sram_clock__enable=1; otherwise ack=0.
//  - On an enabled edge with winner w: sram_select<=1, sram_* <= fields of w, last_grant<=w;
//    rd_pend<=onehot(w) if read, else 0. With no req: sram_select<=0, last_grant holds, rd_pend<=0.
//  - Next enabled edge (SRAM performs access): rdata_valid<=rd_pend.
//  - Read latency: accepted at enabled edge E0 -> rdata_valid/rdata valid after E0+2 enabled edges.
//  - Writes return nothing. Accesses execute in acceptance order, so write at E0 then read of the
//    same address at E0+1 returns the new data.
//  - Requester samples ack at the same edge and may drop req or present the next request in the
//    following cycle. A held req is not re-granted while an ack is in flight.
//  - rdata_valid qualifies rdata only in enabled cycles. With enable low, all registers hold,
//    including rdata_valid.
//  - Reset mid-operation clears rd_pend and rdata_valid; in-flight reads are dropped, never reported.
//  - Fairness: a continuously requesting requester is granted within num_req enabled cycles.
// STRUCTURE
//  - Shared package: access-type encoding (READ=1/WRITE=0) and a clog2 helper for idx_width.
//  - Sub-module se_sram_rr_picker: combinational; inputs (req, last_grant); outputs
//    (any, winner idx, winner onehot).
//  - Top level: request mux, sram_* registers, last_grant register, rd_pend/rdata_valid pipeline.
// TESTING (bench: arbiter + se_sram_srw, address_width=8, data_width=8, num_req=4)
//  1. Reset, then req[1] write 0xA5 @0x10, then req[0] read 0x10:
//     ack[1] then ack[0] in consecutive cycles; rdata_valid=4'b0001 with rdata=0xA5 two enabled edges later.
//  2. req=4'b1111 held: ack sequence 0,1,2,3,0,1 on consecutive cycles; sram_select stays 1.
//  3. req=4'b1010 held, last_grant=1: grants alternate 3,1,3,1; never 0 or 2.
//  4. sram_clock__enable pattern 1,0,0,1 with read pending: ack=0 and all sram_* held while low;
//     rdata_valid rises after the 2nd enabled edge.
//  5. sram_reset_n pulsed low one cycle after a read is accepted:
//     sram_select=0 immediately; rdata_valid stays 0; next grant goes to requester 0.
//  6. Read-after-write from different requesters to 0x3F (write 0x5C then read):
//     read returns 0x5C; no request left idle is ever acked.

Source files
------------

// File: rtl/se_sram_srw_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// se_sram_srw_arbiter_pkg
// Shared definitions for the se_sram_srw round-robin arbiter.
//   access_t : encoding of the SRAM read_not_write strobe (READ=1, WRITE=0)
//   clog2    : ceiling log2, used by instantiators to derive idx_width
// ----------------------------------------------------------------------------
package se_sram_srw_arbiter_pkg;

    typedef enum logic {
        ACCESS_WRITE = 1'b0,
        ACCESS_READ  = 1'b1
    } access_t;

    // Returns the number of bits needed to index 'value' items (minimum 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        int unsigned span;
        bits = 0;
        span = 1;
        while (span < value) begin
            span = span << 1;
            bits = bits + 1;
        end
        if (bits == 0) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage : se_sram_srw_arbiter_pkg

// File: rtl/se_sram_rr_picker.sv
// ----------------------------------------------------------------------------
// se_sram_rr_picker
// Combinational round-robin selector. Searches req starting at the requester
// after last_grant and wrapping around, returning the first asserted one.
//   req           in  num_req    pending requests
//   last_grant    in  idx_width  requester granted most recently
//   any           out 1          at least one request pending
//   winner        out idx_width  index of the selected requester
//   winner_onehot out num_req    one-hot form of winner (zero when !any)
// ----------------------------------------------------------------------------
module se_sram_rr_picker
    import se_sram_srw_arbiter_pkg::*;
#(
    parameter int unsigned num_req   = 4,
    parameter int unsigned idx_width = 2
) (
    input  logic [num_req-1:0]   req,
    input  logic [idx_width-1:0] last_grant,
    output logic                 any,
    output logic [idx_width-1:0] winner,
    output logic [num_req-1:0]   winner_onehot
);

    localparam logic [idx_width-1:0] LAST_IDX = idx_width'(num_req - 1);

    logic [idx_width-1:0] scan_idx;

    // scan_idx walks the ring once, beginning just after last_grant; the
    // first hit wins and later hits are ignored.
    always_comb begin
        any           = 1'b0;
        winner        = '0;
        winner_onehot = '0;
        scan_idx      = (last_grant == LAST_IDX) ? '0 : last_grant + 1'b1;
        for (int unsigned k = 0; k < num_req; k++) begin
            if (!any && req[scan_idx]) begin
                any                     = 1'b1;
                winner                  = scan_idx;
                winner_onehot[scan_idx] = 1'b1;
            end
            scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
        end
    end

endmodule : se_sram_rr_picker

// File: rtl/se_sram_srw_arbiter.sv
// ----------------------------------------------------------------------------
// se_sram_srw_arbiter
// Round-robin arbiter sharing one single-port SRAM (se_sram_srw) between
// num_req requesters; one access accepted per enabled cycle.
//   sram_clock, sram_clock__enable, sram_reset_n : clock, enable, async reset (low)
//   req / req_read_not_write / req_address / req_write_data : per-requester
//       request, packed with requester i at [i*width +: width]
//   ack          : one-hot, combinational; the request is taken at this edge
//   rdata_valid  : one-hot, registered; owner of the current rdata
//   rdata        : SRAM read data, passed straight through
//   sram_select / sram_read_not_write / sram_address / sram_write_data :
//       registered SRAM command outputs
//   sram_data_in : SRAM data_out
// A read accepted at enabled edge E0 is issued to the SRAM at E0, performed
// by the SRAM at the next enabled edge, and flagged on rdata_valid then.
// ----------------------------------------------------------------------------
module se_sram_srw_arbiter
    import se_sram_srw_arbiter_pkg::*;
#(
    parameter int unsigned address_width = 16,
    parameter int unsigned data_width    = 8,
    parameter int unsigned num_req       = 4,
    parameter int unsigned idx_width     = 2
) (
    input  logic                              sram_clock,
    input  logic                              sram_clock__enable,
    input  logic                              sram_reset_n,
    input  logic [num_req-1:0]                req,
    input  logic [num_req-1:0]                req_read_not_write,
    input  logic [num_req*address_width-1:0]  req_address,
    input  logic [num_req*data_width-1:0]     req_write_data,
    output logic [num_req-1:0]                ack,
    output logic [num_req-1:0]                rdata_valid,
    output logic [data_width-1:0]             rdata,
    output logic                              sram_select,
    output logic                              sram_read_not_write,
    output logic [address_width-1:0]          sram_address,
    output logic [data_width-1:0]             sram_write_data,
    input  logic [data_width-1:0]             sram_data_in
);

    localparam logic [idx_width-1:0] LAST_IDX = idx_width'(num_req - 1);

    logic [idx_width-1:0]     last_grant;
    logic [num_req-1:0]       rd_pend;

    logic                     pick_any;
    logic [idx_width-1:0]     pick_idx;
    logic [num_req-1:0]       pick_onehot;

    access_t                  mux_access;
    logic [address_width-1:0] mux_address;
    logic [data_width-1:0]    mux_write_data;

    se_sram_rr_picker #(
        .num_req   (num_req),
        .idx_width (idx_width)
    ) u_picker (
        .req           (req),
        .last_grant    (last_grant),
        .any           (pick_any),
        .winner        (pick_idx),
        .winner_onehot (pick_onehot)
    );

    // Acceptance happens only on an enabled edge outside reset.
    always_comb begin
        ack = '0;
        if (sram_reset_n && sram_clock__enable && pick_any) begin
            ack = pick_onehot;
        end
    end

    // AND-OR request mux keyed by the one-hot winner.
    always_comb begin
        mux_access     = ACCESS_WRITE;
        mux_address    = '0;
        mux_write_data = '0;
        for (int unsigned i = 0; i < num_req; i++) begin
            if (pick_onehot[i]) begin
                mux_access     = access_t'(req_read_not_write[i]);
                mux_address    = req_address[i*address_width +: address_width];
                mux_write_data = req_write_data[i*data_width +: data_width];
            end
        end
    end

    always_ff @(posedge sram_clock or negedge sram_reset_n) begin
        if (!sram_reset_n) begin
            sram_select         <= 1'b0;
            sram_read_not_write <= 1'b0;
            sram_address        <= '0;
            sram_write_data     <= '0;
            last_grant          <= LAST_IDX;
            rd_pend             <= '0;
            rdata_valid         <= '0;
        end else if (sram_clock__enable) begin
            // The SRAM performs last cycle's command at this edge, so its
            // read owner becomes visible together with the data.
            rdata_valid <= rd_pend;
            if (pick_any) begin
                sram_select         <= 1'b1;
                sram_read_not_write <= (mux_access == ACCESS_READ);
                sram_address        <= mux_address;
                sram_write_data     <= mux_write_data;
                last_grant          <= pick_idx;
                rd_pend             <= (mux_access == ACCESS_READ) ? pick_onehot : '0;
            end else begin
                sram_select <= 1'b0;
                rd_pend     <= '0;
            end
        end
    end

    assign rdata = sram_data_in;

endmodule : se_sram_srw_arbiter

// File: tb/tb_se_sram_srw_arbiter.sv
// ----------------------------------------------------------------------------
// tb_se_sram_srw_arbiter
// Arbiter plus a behavioural single-port SRAM (registered read data).
// Expected grants come from a round-robin reference; expected reads are
// queued at acceptance with the enabled-edge index they are due on.
// ----------------------------------------------------------------------------
module tb_se_sram_srw_arbiter;
    import se_sram_srw_arbiter_pkg::*;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned NR = 4;
    localparam int unsigned IW = clog2(NR);

    logic           clk;
    logic           en;
    logic           rst_n;
    logic [NR-1:0]  req;
    logic [NR-1:0]  req_rnw;
    logic [NR*AW-1:0] req_addr_bus;
    logic [NR*DW-1:0] req_wd_bus;
    logic [NR-1:0]  ack;
    logic [NR-1:0]  rdata_valid;
    logic [DW-1:0]  rdata;
    logic           sram_select;
    logic           sram_read_not_write;
    logic [AW-1:0]  sram_address;
    logic [DW-1:0]  sram_write_data;
    logic [DW-1:0]  sram_data_in;

    logic [AW-1:0]  t_addr [NR];
    logic [DW-1:0]  t_wd   [NR];

    assign req_addr_bus = {t_addr[3], t_addr[2], t_addr[1], t_addr[0]};
    assign req_wd_bus   = {t_wd[3], t_wd[2], t_wd[1], t_wd[0]};

    se_sram_srw_arbiter #(
        .address_width (AW),
        .data_width    (DW),
        .num_req       (NR),
        .idx_width     (IW)
    ) dut (
        .sram_clock          (clk),
        .sram_clock__enable  (en),
        .sram_reset_n        (rst_n),
        .req                 (req),
        .req_read_not_write  (req_rnw),
        .req_address         (req_addr_bus),
        .req_write_data      (req_wd_bus),
        .ack                 (ack),
        .rdata_valid         (rdata_valid),
        .rdata               (rdata),
        .sram_select         (sram_select),
        .sram_read_not_write (sram_read_not_write),
        .sram_address        (sram_address),
        .sram_write_data     (sram_write_data),
        .sram_data_in        (sram_data_in)
    );

    // Behavioural SRAM
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (en && sram_select) begin
            if (sram_read_not_write) sram_data_in <= mem[sram_address];
            else                     mem[sram_address] <= sram_write_data;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          who;
        logic [7:0]  data;
        int          due;
    } rd_exp_t;

    rd_exp_t     sb[$];
    int          grant_log[$];
    logic [7:0]  shadow [256];
    int          m_last;
    logic        m_sel;
    logic        m_rnw;
    logic [7:0]  m_addr;
    logic [7:0]  m_wd;
    logic [3:0]  m_valid;
    int          edges;
    int          n_checks;
    int          n_fail;
    logic [7:0]  got_rdata;
    logic [3:0]  got_owner;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last  = NR - 1;
        m_sel   = 1'b0;
        m_rnw   = 1'b0;
        m_addr  = '0;
        m_wd    = '0;
        m_valid = '0;
        sb.delete();
    endtask

    // Called at a negedge; asserts reset at once and releases one cycle later.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_select", sram_select, 0);
        check("rst_valid", rdata_valid, 0);
        check("rst_addr", sram_address, 0);
        check("rst_ack", ack, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: check ack against the reference, update the model, then
    // check registered outputs on the following negedge.
    task automatic step();
        int         w;
        int         i;
        logic [3:0] exp_ack;
        #1;
        w = -1;
        if (rst_n) begin
            for (int k = 1; k <= NR; k++) begin
                i = (m_last + k) % NR;
                if (w < 0 && req[i]) w = i;
            end
        end
        exp_ack = (w >= 0 && en) ? 4'(1 << w) : 4'b0;
        check("ack", ack, exp_ack);
        check("ack_idle", ack & ~req, 0);
        if (exp_ack != 0) begin
            grant_log.push_back(w);
            m_last = w;
            m_sel  = 1'b1;
            m_rnw  = req_rnw[w];
            m_addr = t_addr[w];
            m_wd   = t_wd[w];
            if (req_rnw[w]) sb.push_back('{w, shadow[t_addr[w]], edges + 2});
            else            shadow[t_addr[w]] = t_wd[w];
        end else if (en && rst_n) begin
            m_sel = 1'b0;
        end
        @(posedge clk);
        if (en && rst_n) edges++;
        @(negedge clk);
        check("sram_select", sram_select, m_sel);
        check("sram_rnw", sram_read_not_write, m_rnw);
        check("sram_address", sram_address, m_addr);
        check("sram_wdata", sram_write_data, m_wd);
        if (!rst_n) begin
            m_valid = '0;
        end else if (en) begin
            m_valid = '0;
            if (sb.size() > 0 && sb[0].due == edges) begin
                m_valid = 4'(1 << sb[0].who);
                check("rdata", rdata, sb[0].data);
                got_rdata = rdata;
                got_owner = rdata_valid;
                void'(sb.pop_front());
            end
        end
        check("rdata_valid", rdata_valid, m_valid);
    endtask

    task automatic set_req(input int r, input logic rnw, input logic [7:0] a, input logic [7:0] d);
        req_rnw[r] = rnw;
        t_addr[r]  = a;
        t_wd[r]    = d;
    endtask

    initial begin
        int exp2[6];
        int exp3[4];
        exp2 = '{0, 1, 2, 3, 0, 1};
        exp3 = '{3, 1, 3, 1};
        n_checks = 0;
        n_fail   = 0;
        edges    = 0;
        en       = 1'b1;
        req      = '0;
        req_rnw  = '0;
        for (int r = 0; r < NR; r++) begin
            t_addr[r] = '0;
            t_wd[r]   = '0;
        end
        for (int a = 0; a < 256; a++) shadow[a] = '0;
        got_rdata = '0;
        got_owner = '0;
        do_reset();

        // 1: write 0xA5 @0x10 by requester 1, then read it back by requester 0
        set_req(1, 1'b0, 8'h10, 8'hA5);
        req = 4'b0010; step();
        set_req(0, 1'b1, 8'h10, 8'h00);
        req = 4'b0001; step();
        req = 4'b0000; step();
        step();
        check("t1_rdata", got_rdata, 8'hA5);
        check("t1_owner", got_owner, 4'b0001);

        // 2: all requesting; strict rotation from requester 0
        do_reset();
        grant_log.delete();
        set_req(0, 1'b1, 8'h10, 8'h00);
        set_req(1, 1'b0, 8'h20, 8'h11);
        set_req(2, 1'b1, 8'h20, 8'h00);
        set_req(3, 1'b0, 8'h30, 8'h33);
        req = 4'b1111;
        for (int c = 0; c < 6; c++) step();
        for (int c = 0; c < 6; c++) check("t2_order", grant_log[c], exp2[c]);
        req = 4'b0000; step(); step();

        // 3: last_grant=1, then 1 and 3 both held
        do_reset();
        req = 4'b0010; step();
        grant_log.delete();
        req = 4'b1010;
        for (int c = 0; c < 4; c++) step();
        for (int c = 0; c < 4; c++) check("t3_order", grant_log[c], exp3[c]);
        req = 4'b0000; step();

        // 4: enable 1,0,0,1 with a read in flight
        req = 4'b0001; step();
        set_req(2, 1'b0, 8'h44, 8'h77);
        req = 4'b0100;
        en = 1'b0; step(); step();
        check("t4_held_valid", rdata_valid, 0);
        en = 1'b1; step();
        check("t4_valid", rdata_valid, 4'b0001);
        req = 4'b0000; step();

        // 5: reset one cycle after a read is accepted
        req = 4'b0001; step();
        req = 4'b0000;
        do_reset();
        step();
        check("t5_no_valid", rdata_valid, 0);
        grant_log.delete();
        req = 4'b1111; step();
        check("t5_first_grant", grant_log[0], 0);
        req = 4'b0000; step(); step();

        // 6: RAW across requesters at 0x3F
        set_req(2, 1'b0, 8'h3F, 8'h5C);
        set_req(3, 1'b1, 8'h3F, 8'h00);
        got_rdata = '0;
        req = 4'b0100; step();
        req = 4'b1000; step();
        req = 4'b0000; step(); step();
        check("t6_rdata", got_rdata, 8'h5C);
        check("t6_owner", got_owner, 4'b1000);

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_se_sram_srw_arbiter
